// File: rtl/mc_data_sync_pkg.sv
// Shared helpers for the multi-channel synchronizer: channel-index width, enable modes
// and the round-robin grant search.
// Pure combinational helpers; no latency or flow control of their own.
package mc_sync_pkg;

    localparam int MODE_LEVEL  = 0;
    localparam int MODE_TOGGLE = 1;

    // A single channel still needs a one-bit index on the output.
    function automatic int ch_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // First requesting channel at or after ptr, wrapping modulo num_ch (num_ch <= 16).
    function automatic int rr_grant(input logic [15:0] req, input int ptr, input int num_ch);
        int         g;
        logic [3:0] idx;
        g = ptr;
        for (int i = 15; i >= 0; i--) begin
            if (i < num_ch) begin
                idx = 4'((ptr + i) % num_ch);
                if (req[idx]) g = int'(idx);
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/mc_data_sync_pulse_gen.sv
// Per-channel enable synchronizer with edge flop; emits a one-cycle capture pulse.
// Latency: pulse is high after NUM_STAGES edges; no backpressure (free-running).
// Level mode pulses on rising edges only, toggle mode on every edge.
module sync_pulse_gen
    import mc_sync_pkg::*;
#(
    parameter int NUM_STAGES  = 2,
    parameter int ENABLE_MODE = MODE_LEVEL
) (
    input  logic CLK,
    input  logic RST,
    input  logic enable,
    output logic pulse
);

    logic [NUM_STAGES-1:0] chain;
    logic                  edge_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            chain  <= '0;
            edge_q <= 1'b0;
        end else begin
            chain  <= {chain[NUM_STAGES-2:0], enable};
            edge_q <= chain[NUM_STAGES-1];
        end
    end

    // The edge flop resets to 0 and fills from the chain, so an enable that is
    // already high after reset produces exactly one rising-edge pulse.
    generate
        if (ENABLE_MODE == MODE_TOGGLE) begin : g_toggle
            assign pulse = chain[NUM_STAGES-1] ^ edge_q;
        end else begin : g_level
            assign pulse = chain[NUM_STAGES-1] & ~edge_q;
        end
    endgenerate

endmodule

// File: rtl/mc_data_sync.sv
// NUM_CH enable-qualified buses synchronized into CLK, held per channel, merged round-robin.
// Latency: out_valid NUM_STAGES+2 edges after enable is first sampled; one word/cycle throughput.
// Backpressure: out_ready=0 stalls the output slice; a new word on a still-pending channel is dropped and flags overrun. Option: MC_DATA_SYNC_PARITY_EN.
module mc_data_sync
    import mc_sync_pkg::*;
#(
    parameter int  NUM_CH      = 4,
    parameter int  BUS_WIDTH   = 8,
    parameter int  NUM_STAGES  = 2,
    parameter int  ENABLE_MODE = MODE_LEVEL,
    localparam int CH_W        = ch_width(NUM_CH)
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [NUM_CH*BUS_WIDTH-1:0] unsync_bus,
    input  logic [NUM_CH-1:0]           bus_enable,
    input  logic                        out_ready,
    input  logic [NUM_CH-1:0]           clr_overrun,
    output logic                        out_valid,
    output logic [BUS_WIDTH-1:0]        out_data,
    output logic [CH_W-1:0]             out_ch,
    output logic [NUM_CH-1:0]           overrun
`ifdef MC_DATA_SYNC_PARITY_EN
    ,
    input  logic [NUM_CH-1:0]           src_parity,
    output logic                        out_parity,
    output logic [NUM_CH-1:0]           par_err
`endif
);

    typedef struct packed {
        logic [CH_W-1:0]      ch;
        logic [BUS_WIDTH-1:0] data;
    } out_word_t;

    logic [NUM_CH-1:0]    pulse;
    logic [NUM_CH-1:0]    pending;
    logic [NUM_CH-1:0]    xfer;
    logic [NUM_CH-1:0]    capture;
    logic [NUM_CH-1:0]    ovr_set;
    logic [BUS_WIDTH-1:0] slice [NUM_CH];
    logic [BUS_WIDTH-1:0] hold  [NUM_CH];
    logic [CH_W-1:0]      ptr;
    logic [CH_W-1:0]      grant;
    logic                 load;
    out_word_t            out_q;

    genvar gc;
    generate
        for (gc = 0; gc < NUM_CH; gc++) begin : g_ch
            sync_pulse_gen #(
                .NUM_STAGES  (NUM_STAGES),
                .ENABLE_MODE (ENABLE_MODE)
            ) u_sync (
                .CLK    (CLK),
                .RST    (RST),
                .enable (bus_enable[gc]),
                .pulse  (pulse[gc])
            );
        end
    endgenerate

    // A pulse landing on the channel being transferred refills it instead of overrunning.
    always_comb begin
        grant   = CH_W'(rr_grant(16'(pending), int'(ptr), NUM_CH));
        load    = (!out_valid || out_ready) && (|pending);
        xfer    = '0;
        capture = '0;
        ovr_set = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            slice[i]   = unsync_bus[i*BUS_WIDTH +: BUS_WIDTH];
            xfer[i]    = load && (grant == CH_W'(i));
            capture[i] = pulse[i] && (!pending[i] || xfer[i]);
            ovr_set[i] = pulse[i] && pending[i] && !xfer[i];
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pending <= '0;
            overrun <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                hold[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (capture[i]) begin
                    hold[i]    <= slice[i];
                    pending[i] <= 1'b1;
                end else if (xfer[i]) begin
                    pending[i] <= 1'b0;
                end
                if (ovr_set[i]) begin
                    overrun[i] <= 1'b1;
                end else if (clr_overrun[i]) begin
                    overrun[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            out_q     <= '0;
            out_valid <= 1'b0;
            ptr       <= '0;
        end else if (load) begin
            out_q.ch   <= grant;
            out_q.data <= hold[grant];
            out_valid  <= 1'b1;
            ptr        <= (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + CH_W'(1);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign out_data = out_q.data;
    assign out_ch   = out_q.ch;

`ifdef MC_DATA_SYNC_PARITY_EN
    logic [NUM_CH-1:0] par_q;

    // Even parity is taken from the same slice that is captured, so it travels with hold[].
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            par_q   <= '0;
            par_err <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (capture[i]) begin
                    par_q[i] <= ^slice[i];
                end
                if (capture[i] && ((^slice[i]) != src_parity[i])) begin
                    par_err[i] <= 1'b1;
                end else if (clr_overrun[i]) begin
                    par_err[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            out_parity <= 1'b0;
        end else if (load) begin
            out_parity <= par_q[grant];
        end
    end
`endif

endmodule
